// File: rtl/uart_command_pkg.sv
// Shared definitions for the UART command master: command encodings,
// frame header codes and controller state encoding.
package uart_command_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE     = 2'b00,
    CMD_READ      = 2'b01,
    CMD_ALU_OP    = 2'b10,
    CMD_ALU_NO_OP = 2'b11
  } cmd_type_e;

  localparam logic [7:0] FRAME_CODE_WRITE     = 8'hAA;
  localparam logic [7:0] FRAME_CODE_READ      = 8'hBB;
  localparam logic [7:0] FRAME_CODE_ALU_OP    = 8'hCC;
  localparam logic [7:0] FRAME_CODE_ALU_NO_OP = 8'hDD;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    SEND           = 3'd1,
    WAIT_BUSY_HIGH = 3'd2,
    WAIT_BUSY_LOW  = 3'd3,
    WAIT_RESPONSE  = 3'd4,
    RESPOND        = 3'd5
  } state_e;

  // Number of bytes in the outgoing frame for each command type.
  function automatic logic [2:0] frame_length(input cmd_type_e t);
    case (t)
      CMD_WRITE:  frame_length = 3'd3;
      CMD_READ:   frame_length = 3'd2;
      CMD_ALU_OP: frame_length = 3'd4;
      default:    frame_length = 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/response_timeout_counter.sv
// Counts idle cycles while waiting for a response; expired is high once
// the count reaches TIMEOUT_CYCLES-1 and stays there until cleared.
module response_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

  // Clear has priority; the count saturates at the expiry value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_command_master.sv
// Turns register-file commands into UART byte frames, paces them against
// the transmitter busy flag and collects the one- or two-byte reply.
module uart_command_master #(
  parameter int DATA_WIDTH          = 8,
  parameter int REGISTER_FILE_DEPTH = 16,
  parameter int TIMEOUT_CYCLES      = 4096
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [1:0]                             cmd_type,
  input  logic [$clog2(REGISTER_FILE_DEPTH)-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0]                  cmd_write_data,
  input  logic [DATA_WIDTH-1:0]                  cmd_operand_a,
  input  logic [DATA_WIDTH-1:0]                  cmd_operand_b,
  input  logic [3:0]                             cmd_ALU_function,
  input  logic                                   transmitter_busy_synchronized,
  output logic                                   transmitter_parallel_data_valid,
  output logic [DATA_WIDTH-1:0]                  transmitter_parallel_data,
  input  logic                                   receiver_parallel_data_valid_synchronized,
  input  logic [DATA_WIDTH-1:0]                  receiver_parallel_data_synchronized,
  output logic                                   response_valid,
  output logic [2*DATA_WIDTH-1:0]                response_data,
  output logic                                   response_timeout
);

  import uart_command_pkg::*;

  state_e                state, state_next;
  cmd_type_e             type_r;
  logic [2:0]            frame_len_r;
  logic [1:0]            byte_idx;
  logic [DATA_WIDTH-1:0] frame_r    [4];
  logic [DATA_WIDTH-1:0] frame_next [4];
  logic [1:0]            rx_count;
  logic [DATA_WIDTH-1:0] rx_low;

  logic accept, send_fire, last_byte, rx_take, rx_done, timeout_fire;
  logic timer_clear, timer_expired;

  assign cmd_ready      = (state == IDLE);
  assign accept         = cmd_valid && cmd_ready;
  assign send_fire      = (state == SEND) && !transmitter_busy_synchronized;
  assign last_byte      = ({1'b0, byte_idx} == (frame_len_r - 3'd1));
  assign rx_take        = (state == WAIT_RESPONSE) && receiver_parallel_data_valid_synchronized;
  // A read needs one byte; ALU replies need two, low byte first.
  assign rx_done        = rx_take && ((type_r == CMD_READ) || (rx_count == 2'd1));
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_fire   = (state == WAIT_RESPONSE) && !receiver_parallel_data_valid_synchronized
                          && timer_expired;
  assign timer_clear    = ((state != WAIT_RESPONSE) && (state_next == WAIT_RESPONSE)) || rx_take;
  assign response_valid = (state == RESPOND);

  response_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (state == WAIT_RESPONSE),
    .expired(timer_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic for frame transmission and response collection.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:           if (cmd_valid) state_next = SEND;
      SEND:           if (!transmitter_busy_synchronized) state_next = WAIT_BUSY_HIGH;
      WAIT_BUSY_HIGH: if (transmitter_busy_synchronized) state_next = WAIT_BUSY_LOW;
      WAIT_BUSY_LOW: begin
        if (!transmitter_busy_synchronized) begin
          if (!last_byte)              state_next = SEND;
          else if (type_r == CMD_WRITE) state_next = IDLE;
          else                          state_next = WAIT_RESPONSE;
        end
      end
      WAIT_RESPONSE:  if (rx_done || timeout_fire) state_next = RESPOND;
      RESPOND:        state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  // Assemble the outgoing frame from the command fields; unused slots are zero.
  always_comb begin
    for (int i = 0; i < 4; i++) frame_next[i] = '0;
    case (cmd_type_e'(cmd_type))
      CMD_WRITE: begin
        frame_next[0] = DATA_WIDTH'(FRAME_CODE_WRITE);
        frame_next[1] = DATA_WIDTH'(cmd_address);
        frame_next[2] = cmd_write_data;
      end
      CMD_READ: begin
        frame_next[0] = DATA_WIDTH'(FRAME_CODE_READ);
        frame_next[1] = DATA_WIDTH'(cmd_address);
      end
      CMD_ALU_OP: begin
        frame_next[0] = DATA_WIDTH'(FRAME_CODE_ALU_OP);
        frame_next[1] = cmd_operand_a;
        frame_next[2] = cmd_operand_b;
        frame_next[3] = DATA_WIDTH'(cmd_ALU_function);
      end
      default: begin
        frame_next[0] = DATA_WIDTH'(FRAME_CODE_ALU_NO_OP);
        frame_next[1] = DATA_WIDTH'(cmd_ALU_function);
      end
    endcase
  end

  // Frame payload is captured on accept; it carries no control meaning so it is not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 4; i++) frame_r[i] <= frame_next[i];
    end
  end

  // Command type, frame length and byte position within the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_r      <= CMD_WRITE;
      frame_len_r <= 3'd0;
      byte_idx    <= 2'd0;
    end else if (accept) begin
      type_r      <= cmd_type_e'(cmd_type);
      frame_len_r <= frame_length(cmd_type_e'(cmd_type));
      byte_idx    <= 2'd0;
    end else if ((state == WAIT_BUSY_LOW) && !transmitter_busy_synchronized && !last_byte) begin
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // One-cycle transmit strobe; the data register keeps the last byte sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      transmitter_parallel_data_valid <= 1'b0;
      transmitter_parallel_data       <= '0;
    end else begin
      transmitter_parallel_data_valid <= send_fire;
      if (send_fire) transmitter_parallel_data <= frame_r[byte_idx];
    end
  end

  // Received-byte counter and low-byte holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count <= 2'd0;
      rx_low   <= '0;
    end else if (accept) begin
      rx_count <= 2'd0;
    end else if (rx_take) begin
      rx_count <= rx_count + 2'd1;
      if (rx_count == 2'd0) rx_low <= receiver_parallel_data_synchronized;
    end
  end

  // Response result; updated only when a response completes so it holds in between.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      response_data    <= '0;
      response_timeout <= 1'b0;
    end else if (rx_done) begin
      response_timeout <= 1'b0;
      if (type_r == CMD_READ)
        response_data <= {{DATA_WIDTH{1'b0}}, receiver_parallel_data_synchronized};
      else
        response_data <= {receiver_parallel_data_synchronized, rx_low};
    end else if (timeout_fire) begin
      response_timeout <= 1'b1;
      response_data    <= '0;
    end
  end

endmodule

// File: tb/tb_uart_command_master.sv
// Scoreboard bench for uart_command_master: a transmitter/receiver model
// drives the UART side, expected bytes and responses are queued at issue.
module tb_uart_command_master;

  localparam int DW       = 8;
  localparam int DEPTH    = 16;
  localparam int TO       = 64;
  localparam int BUSY_CYC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'b00;
  logic [3:0]  cmd_address = '0;
  logic [7:0]  cmd_write_data = '0, cmd_operand_a = '0, cmd_operand_b = '0;
  logic [3:0]  cmd_ALU_function = '0;
  logic        busy = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_timeout;

  typedef struct packed {
    logic [15:0] data;
    logic        timeout;
    logic        check_time;
  } resp_t;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned last_fall = 0;
  int          falls = 0;
  int          tx_pulses = 0;
  logic [7:0]  exp_tx[$];
  resp_t       exp_resp[$];
  logic [7:0]  last_tx_exp = '0;
  logic [15:0] hold_exp = '0;
  logic        prev_txv = 1'b0;
  logic        prev_rv = 1'b0;

  uart_command_master #(
    .DATA_WIDTH(DW), .REGISTER_FILE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_address(cmd_address), .cmd_write_data(cmd_write_data),
    .cmd_operand_a(cmd_operand_a), .cmd_operand_b(cmd_operand_b),
    .cmd_ALU_function(cmd_ALU_function),
    .transmitter_busy_synchronized(busy),
    .transmitter_parallel_data_valid(tx_valid),
    .transmitter_parallel_data(tx_data),
    .receiver_parallel_data_valid_synchronized(rx_valid),
    .receiver_parallel_data_synchronized(rx_data),
    .response_valid(resp_valid), .response_data(resp_data),
    .response_timeout(resp_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  // Transmitter model: each accepted byte keeps busy high for BUSY_CYC cycles.
  always begin
    @(negedge clk);
    if (tx_valid && !reset) begin
      @(posedge clk); #1 busy = 1'b1;
      repeat (BUSY_CYC) @(posedge clk);
      #1 busy = 1'b0;
      last_fall = cyc;
      falls++;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte or a response.
  always @(negedge clk) begin
    if (reset) begin
      prev_txv = 1'b0;
      prev_rv = 1'b0;
      last_tx_exp = '0;
      exp_tx.delete();
      exp_resp.delete();
    end else begin
      if (tx_valid) begin
        tx_pulses++;
        check("tx_pulse_single", {31'd0, prev_txv}, 32'd0);
        if (exp_tx.size() == 0) fail_now("unexpected_tx_byte", {24'd0, tx_data});
        else begin
          last_tx_exp = exp_tx.pop_front();
          check("tx_byte", {24'd0, tx_data}, {24'd0, last_tx_exp});
        end
      end else begin
        check("tx_hold", {24'd0, tx_data}, {24'd0, last_tx_exp});
      end
      prev_txv = tx_valid;
      if (resp_valid) begin
        check("resp_pulse_single", {31'd0, prev_rv}, 32'd0);
        if (exp_resp.size() == 0) fail_now("unexpected_response", {16'd0, resp_data});
        else begin
          resp_t e;
          e = exp_resp.pop_front();
          check("resp_data", {16'd0, resp_data}, {16'd0, e.data});
          check("resp_timeout", {31'd0, resp_timeout}, {31'd0, e.timeout});
          if (e.check_time) check("resp_cycle", cyc, last_fall + 1 + TO);
        end
      end
      prev_rv = resp_valid;
    end
  end

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) fail_now("cmd_ready_wait_expired", guard);
  endtask

  task automatic wait_falls(input int target);
    int guard = 0;
    while (falls < target && guard < 2000) begin
      @(posedge clk); #2;
      guard++;
    end
    if (falls < target) fail_now("frame_wait_expired", falls);
  endtask

  task automatic rx_byte(input logic [7:0] v, input int delay);
    repeat (delay) @(posedge clk);
    #2 rx_valid = 1'b1; rx_data = v;
    @(posedge clk); #2 rx_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] wd,
                       input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn);
    wait_ready();
    cmd_type = t; cmd_address = addr; cmd_write_data = wd;
    cmd_operand_a = a; cmd_operand_b = b; cmd_ALU_function = fn;
    cmd_valid = 1'b1;
    @(posedge clk); #2 cmd_valid = 1'b0;
    // A stray receiver byte while the frame is still going out must be ignored.
    rx_valid = 1'b1; rx_data = 8'($urandom);
    @(posedge clk); #2 rx_valid = 1'b0;
  endtask

  // Push the expected frame bytes for a command; returns the frame length.
  task automatic push_frame(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] wd,
                            input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn,
                            output int n);
    case (t)
      2'b00: begin exp_tx.push_back(8'hAA); exp_tx.push_back({4'h0, addr}); exp_tx.push_back(wd); n = 3; end
      2'b01: begin exp_tx.push_back(8'hBB); exp_tx.push_back({4'h0, addr}); n = 2; end
      2'b10: begin exp_tx.push_back(8'hCC); exp_tx.push_back(a); exp_tx.push_back(b);
                   exp_tx.push_back({4'h0, fn}); n = 4; end
      default: begin exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, fn}); n = 2; end
    endcase
  endtask

  // mode 0: full reply, 1: silence, 2: one byte then silence, 3: reply on the expiry cycle
  task automatic run_cmd(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] wd,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn,
                         input int mode, input logic [7:0] r0, input logic [7:0] r1);
    int n, start;
    resp_t e;
    start = falls;
    push_frame(t, addr, wd, a, b, fn, n);
    if (t != 2'b00) begin
      e.check_time = (mode == 1) || (mode == 3);
      if (mode == 1 || mode == 2) begin e.data = 16'h0; e.timeout = 1'b1; end
      else if (t == 2'b01)        begin e.data = {8'h00, r0}; e.timeout = 1'b0; end
      else                        begin e.data = {r1, r0}; e.timeout = 1'b0; end
      exp_resp.push_back(e);
      hold_exp = e.data;
    end
    issue(t, addr, wd, a, b, fn);
    wait_falls(start + n);
    if (t != 2'b00) begin
      if (mode == 0) begin
        rx_byte(r0, $urandom_range(1, 20));
        if (t != 2'b01) rx_byte(r1, $urandom_range(1, 20));
      end else if (mode == 2) begin
        rx_byte(r0, $urandom_range(1, 20));
      end else if (mode == 3) begin
        int d;
        d = int'(last_fall) + TO - int'(cyc);
        if (d < 0) d = 0;
        rx_byte(r0, d);
      end
    end
    wait_ready();
    check("resp_hold", {16'd0, resp_data}, {16'd0, hold_exp});
    check("tx_queue_drained", exp_tx.size(), 0);
    check("resp_queue_drained", exp_resp.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_data"}, {16'd0, resp_data}, 32'd0);
    check({tag, "_resp_timeout"}, {31'd0, resp_timeout}, 32'd0);
  endtask

  initial begin
    int n, start;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #2 reset = 1'b0;

    run_cmd(2'b00, 4'd3, 8'h5A, 8'h00, 8'h00, 4'd0, 0, 8'h00, 8'h00);
    run_cmd(2'b01, 4'd7, 8'h00, 8'h00, 8'h00, 4'd0, 0, 8'h3C, 8'h00);
    run_cmd(2'b10, 4'd0, 8'h00, 8'h12, 8'h34, 4'd2, 0, 8'h48, 8'h00);
    run_cmd(2'b01, 4'd9, 8'h00, 8'h00, 8'h00, 4'd0, 1, 8'h00, 8'h00);
    run_cmd(2'b01, 4'd2, 8'h00, 8'h00, 8'h00, 4'd0, 3, 8'hA5, 8'h00);
    run_cmd(2'b11, 4'd0, 8'h00, 8'h00, 8'h00, 4'hF, 0, 8'h11, 8'h22);
    run_cmd(2'b10, 4'd0, 8'h00, 8'h9A, 8'hBC, 4'd7, 2, 8'h77, 8'h00);
    run_cmd(2'b11, 4'd0, 8'h00, 8'h00, 8'h00, 4'd5, 0, 8'hEF, 8'hBE);

    // Reset in the middle of an ALU-op frame, after its second byte.
    start = tx_pulses;
    push_frame(2'b10, 4'd0, 8'h00, 8'h55, 8'h66, 4'd9, n);
    issue(2'b10, 4'd0, 8'h00, 8'h55, 8'h66, 4'd9);
    begin
      int guard = 0;
      while (tx_pulses < start + 2 && guard < 500) begin @(posedge clk); #2; guard++; end
      if (tx_pulses < start + 2) fail_now("mid_frame_wait_expired", tx_pulses);
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check_reset_values("midframe_reset");
    @(posedge clk); #2 reset = 1'b0;
    hold_exp = 16'h0;
    repeat (20) @(posedge clk);
    check("no_pulse_after_reset", tx_pulses, start + 2);
    run_cmd(2'b10, 4'd0, 8'h00, 8'h55, 8'h66, 4'd9, 0, 8'h0D, 8'hF0);

    for (int i = 0; i < 30; i++) begin
      logic [1:0] t;
      int mode, r;
      t = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 5);
      if (t == 2'b00)      mode = 0;
      else if (r == 0)     mode = 1;
      else if (r == 1)     mode = (t == 2'b01) ? 3 : 2;
      else                 mode = 0;
      run_cmd(t, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
              mode, 8'($urandom), 8'($urandom));
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
